// File: rtl/alu_issue_stage.sv
// RV32I decode/issue into an external ALU, then a registered result for writeback; 2-cycle latency.
// Valid/ready on both sides: S1 holds while S2 is stalled, S2 holds while wb_ready is low; flush kills both.
`timescale 1ns/1ps
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_data_sel,
    input  logic [XLEN-1:0] alu_res,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic [XLEN-1:0] wb_data,
    output logic            wb_illegal
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [3:0]      w_sel;
    logic            w_illegal;
    logic            w_we;

    logic            r_s1_valid;
    logic [XLEN-1:0] r_alu_a;
    logic [XLEN-1:0] r_alu_b;
    logic [3:0]      r_alu_sel;
    logic [4:0]      r_s1_rd;
    logic            r_s1_we;
    logic            r_s1_illegal;

    logic            r_wb_valid;
    logic [4:0]      r_wb_rd;
    logic            r_wb_we;
    logic [XLEN-1:0] r_wb_data;
    logic            r_wb_illegal;

    logic            w_s2_free;
    logic            w_s1_adv;
    logic            w_accept;

    assign w_opcode = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_rd     = instr[11:7];

    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_sel     = 4'b0000;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_a       = rs1_data;
                w_b       = rs2_data;
                w_sel     = {instr[30], w_f3};
                w_illegal = !((w_f7 == F7_ZERO) ||
                              ((w_f7 == F7_ALT) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OPC_OPIMM: begin
                w_a   = rs1_data;
                w_b   = {{20{instr[31]}}, instr[31:20]};
                // instr[30] is an immediate bit except on right shifts, so ADDI never turns into SUB
                w_sel = {1'b0, w_f3};
                if (w_f3 == 3'b001) begin
                    w_b       = {27'b0, instr[24:20]};
                    w_illegal = (w_f7 != F7_ZERO);
                end else if (w_f3 == 3'b101) begin
                    w_b       = {27'b0, instr[24:20]};
                    w_sel     = {instr[30], w_f3};
                    w_illegal = !((w_f7 == F7_ZERO) || (w_f7 == F7_ALT));
                end
            end
            OPC_LUI: begin
                w_b = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                w_a = pc;
                w_b = {instr[31:12], 12'b0};
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        if (w_illegal) begin
            w_a   = '0;
            w_b   = '0;
            w_sel = 4'b0000;
        end
    end

    assign w_we      = !w_illegal && (w_rd != 5'd0);
    assign w_s2_free = !r_wb_valid || wb_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= 4'b0000;
            r_s1_rd      <= 5'd0;
            r_s1_we      <= 1'b0;
            r_s1_illegal <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_we      <= 1'b0;
            r_wb_data    <= '0;
            r_wb_illegal <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_wb_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_valid   <= 1'b1;
                r_alu_a      <= w_a;
                r_alu_b      <= w_b;
                r_alu_sel    <= w_sel;
                r_s1_rd      <= w_rd;
                r_s1_we      <= w_we;
                r_s1_illegal <= w_illegal;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_wb_valid   <= 1'b1;
                r_wb_rd      <= r_s1_rd;
                r_wb_we      <= r_s1_we;
                r_wb_data    <= alu_res;
                r_wb_illegal <= r_s1_illegal;
            end else if (wb_ready) begin
                r_wb_valid <= 1'b0;
            end
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_data_sel = r_alu_sel;
    assign wb_valid     = r_wb_valid;
    assign wb_rd        = r_wb_rd;
    assign wb_we        = r_wb_we;
    assign wb_data      = r_wb_data;
    assign wb_illegal   = r_wb_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage with an instruction-level reference model and a scoreboard.
`timescale 1ns/1ps
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, wb_valid, wb_ready, wb_we, wb_illegal;
    logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b, alu_res, wb_data;
    logic [3:0]  alu_data_sel;
    logic [4:0]  wb_rd;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_data_sel(alu_data_sel), .alu_res(alu_res),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we),
        .wb_data(wb_data), .wb_illegal(wb_illegal)
    );

    // External ALU as it would sit beside the stage
    always_comb begin
        alu_res = 32'h0;
        case (alu_data_sel)
            4'b0000: alu_res = alu_a + alu_b;
            4'b0001: alu_res = alu_a << alu_b[4:0];
            4'b0010: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
            4'b0011: alu_res = {31'b0, alu_a < alu_b};
            4'b0100: alu_res = alu_a ^ alu_b;
            4'b0101: alu_res = alu_a >> alu_b[4:0];
            4'b0110: alu_res = alu_a | alu_b;
            4'b0111: alu_res = alu_a & alu_b;
            4'b1000: alu_res = alu_a - alu_b;
            4'b1101: alu_res = $signed(alu_a) >>> alu_b[4:0];
            default: alu_res = 32'h0;
        endcase
    end

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t m_exp;
    int   checks = 0;
    int   errors = 0;
    int   n_pop  = 0;
    bit   last_acc = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Architectural result of one instruction, straight from the ISA definitions
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] imm, up, r;
        logic [4:0]  sh;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        ill;
        imm = {{20{ins[31]}}, ins[31:20]};
        up  = {ins[31:12], 12'h000};
        sh  = ins[24:20];
        f7  = ins[31:25];
        f3  = ins[14:12];
        r   = 32'h0;
        ill = 1'b0;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: r = a + b;
                        3'd1: r = a << b[4:0];
                        3'd2: r = {31'b0, $signed(a) < $signed(b)};
                        3'd3: r = {31'b0, a < b};
                        3'd4: r = a ^ b;
                        3'd5: r = a >> b[4:0];
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> b[4:0];
                else ill = 1'b1;
            end
            7'h13: begin
                case (f3)
                    3'd0: r = a + imm;
                    3'd1: if (f7 == 7'h00) r = a << sh; else ill = 1'b1;
                    3'd2: r = {31'b0, $signed(a) < $signed(imm)};
                    3'd3: r = {31'b0, a < imm};
                    3'd4: r = a ^ imm;
                    3'd5: begin
                        if (f7 == 7'h00) r = a >> sh;
                        else if (f7 == 7'h20) r = $signed(a) >>> sh;
                        else ill = 1'b1;
                    end
                    3'd6: r = a | imm;
                    default: r = a & imm;
                endcase
            end
            7'h37: r = up;
            7'h17: r = p + up;
            default: ill = 1'b1;
        endcase
        e.data = ill ? 32'h0 : r;
        e.rd   = ins[11:7];
        e.we   = !ill && (ins[11:7] != 5'd0);
        e.ill  = ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(9, 0);
        if (k <= 3)      w[6:0] = 7'h33;
        else if (k <= 6) w[6:0] = 7'h13;
        else if (k == 7) w[6:0] = 7'h37;
        else if (k == 8) w[6:0] = 7'h17;
        k = $urandom_range(3, 0);
        if (k <= 1)      w[31:25] = 7'h00;
        else if (k == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(3, 0))
            0: return 32'($urandom_range(7, 0));
            1: return 32'hFFFF_FFFF - 32'($urandom_range(3, 0));
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor: retires one expected result per writeback handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush) begin
                q.delete();
            end else if (wb_valid && wb_ready) begin
                n_pop++;
                if (q.size() == 0) begin
                    check("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    m_exp = q.pop_front();
                    check("wb_result", 64'({wb_data, wb_rd, wb_we, wb_illegal}), 64'(m_exp));
                end
            end
        end
    end

    task automatic cycle();
        @(negedge clk);
        last_acc = rst_n && in_valid && in_ready && !flush;
        if (last_acc) q.push_back(model(instr, pc, rs1_data, rs2_data));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        int n;
        instr = i; pc = p; rs1_data = a; rs2_data = b; in_valid = 1'b1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input string name);
        in_valid = 1'b0;
        wb_ready = 1'b1;
        repeat (5) cycle();
        check(name, 64'(q.size()), 64'd0);
    endtask

    int base;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b1;
        instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_wb", 64'({wb_valid, wb_rd, wb_we, wb_data, wb_illegal}), 64'd0);
        check("reset_alu", 64'({alu_a, alu_data_sel}), 64'd0);
        check("reset_alu_b", 64'(alu_b), 64'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // SLTU then result two cycles after launch
        send(32'h0020B1B3, 32'h0, 32'h2, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        check("sltu_sel", 64'(alu_data_sel), 64'h3);
        cycle();
        check("sltu_wb", 64'({wb_valid, wb_rd, wb_we, wb_data}), 64'({1'b1, 5'd3, 1'b1, 32'h1}));
        drain("drain_sltu");

        send(32'h402082B3, 32'h0, 32'h2, 32'hFFFF_FFFF);
        check("sub_sel", 64'(alu_data_sel), 64'h8);
        send(32'hFFF00093, 32'h0, 32'h0, 32'h1234);
        check("addi_sel", 64'(alu_data_sel), 64'h0);
        send(32'h123453B7, 32'h0, 32'hDEAD_BEEF, 32'h1);
        check("lui_ops", 64'({alu_a, alu_b}), 64'({32'h0, 32'h1234_5000}));
        send(32'h12345397, 32'h100, 32'h5, 32'h6);
        check("auipc_a", 64'(alu_a), 64'h100);
        send(32'h00208033, 32'h0, 32'h7, 32'h8);
        drain("drain_basic");

        // Backpressure: two ops fill the pipe, third must wait
        wb_ready = 1'b0;
        send(32'h002080B3, 32'h0, 32'h10, 32'h20);
        send(32'h40208133, 32'h0, 32'h10, 32'h3);
        instr = 32'h0020C1B3; rs1_data = 32'hF0; rs2_data = 32'h0F; in_valid = 1'b1;
        check("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) cycle();
        check("bp_hold", 64'({in_ready, wb_valid, last_acc}), 64'b010);
        base = n_pop;
        wb_ready = 1'b1;
        send(32'h0020C1B3, 32'h0, 32'hF0, 32'h0F);
        in_valid = 1'b0;
        repeat (2) cycle();
        check("bp_retire_rate", 64'(n_pop - base), 64'd3);
        drain("drain_bp");

        // Illegal ops flow in order with legal ones
        send(32'h0000000B, 32'h0, 32'h1, 32'h2);
        send(32'h40309213, 32'h0, 32'h1, 32'h2);
        send(32'h00208333, 32'h0, 32'h3, 32'h4);
        drain("drain_illegal");

        // Flush with both stages occupied
        wb_ready = 1'b0;
        send(32'h002080B3, 32'h0, 32'h1, 32'h1);
        send(32'h00208133, 32'h0, 32'h2, 32'h2);
        flush = 1'b1;
        instr = 32'h002081B3;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_clear", 64'({wb_valid, in_ready}), 64'b01);
        base = n_pop;
        wb_ready = 1'b1;
        repeat (3) cycle();
        check("flush_no_retire", 64'(n_pop - base), 64'd0);
        drain("drain_flush");

        // Asynchronous reset mid-stream
        wb_ready = 1'b0;
        send(32'h002080B3, 32'h0, 32'h9, 32'h9);
        send(32'h00208133, 32'h0, 32'h8, 32'h8);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wb", 64'({wb_valid, wb_rd, wb_we, wb_data, wb_illegal}), 64'd0);
        check("arst_alu", 64'({alu_a, alu_data_sel}), 64'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_release", 64'({in_ready, wb_valid}), 64'b10);
        wb_ready = 1'b1;
        repeat (2) cycle();
        check("arst_no_wb", 64'(wb_valid), 64'd0);

        // Randomized traffic with random writeback stalls
        last_acc = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(3, 0) != 0);
                instr    = rand_instr();
                pc       = $urandom;
                rs1_data = rand_op();
                rs2_data = rand_op();
            end
            wb_ready = ($urandom_range(3, 0) != 0);
            cycle();
        end
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
